// File: rtl/hd_secded_decoder_if.sv
// Codeword-in / decoded-word-out stream bundle for the SEC-DED decoder.
// Master drives the codeword and consumes results; slave is the decoder.
interface hd_secded_decoder_if;
   logic [17:0] in_cw;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_corrected;
   logic        out_uncorr;
   logic [4:0]  out_err_pos;

   modport master (
      output in_cw, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_corrected, out_uncorr, out_err_pos
   );

   modport slave (
      input  in_cw, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_corrected, out_uncorr, out_err_pos
   );
endinterface

// File: rtl/hd_secded_decoder.sv
// SEC-DED decoder for 12-bit data in an 18-bit extended Hamming codeword; HD_STATS_EN adds error counters.
// Latency 2 cycles; in_ready = !out_valid | out_ready, and both stages freeze while the output is stalled.
module hd_secded_decoder
`ifdef HD_STATS_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic                clk,
   input  logic                rst_n,
   hd_secded_decoder_if.slave  bus
`ifdef HD_STATS_EN
   ,
   input  logic                cnt_clr,
   output logic [CNT_W-1:0]    corr_cnt,
   output logic [CNT_W-1:0]    uncorr_cnt
`endif
);
   typedef struct packed {
      logic [11:0] dat;
      logic [4:0]  syn;
      logic        par;
   } s1_t;

   typedef struct packed {
      logic [11:0] data;
      logic        corrected;
      logic        uncorr;
      logic [4:0]  err_pos;
   } res_t;

   localparam logic [4:0] DPOS [12] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10,
                                        5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd17};

   logic en;
   logic s1_vld;
   s1_t  s1_nxt;
   s1_t  s1_q;
   logic out_vld;
   res_t res;
   res_t out_q;

   assign en           = !out_vld || bus.out_ready;
   assign bus.in_ready = en;

   // Parity-bit positions are only needed for the syndrome, so stage 1 keeps just the data field.
   always_comb begin
      s1_nxt     = '0;
      s1_nxt.par = ^bus.in_cw;
      for (int k = 1; k < 18; k++) begin
         if (bus.in_cw[k]) s1_nxt.syn = s1_nxt.syn ^ 5'(k);
      end
      for (int j = 0; j < 12; j++) begin
         s1_nxt.dat[j] = bus.in_cw[DPOS[j]];
      end
   end

   always_comb begin
      res = '0;
      if (s1_q.par) begin
         if (s1_q.syn <= 5'd17) res.corrected = 1'b1;
         else                   res.uncorr    = 1'b1;
      end else if (s1_q.syn != 5'd0) begin
         res.uncorr = 1'b1;
      end
      for (int j = 0; j < 12; j++) begin
         res.data[j] = s1_q.dat[j] ^ (res.corrected && (s1_q.syn == DPOS[j]));
      end
      res.err_pos = (res.corrected || res.uncorr) ? s1_q.syn : 5'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_q    <= '0;
         out_vld <= 1'b0;
         out_q   <= '0;
      end else if (en) begin
         s1_vld  <= bus.in_valid;
         if (bus.in_valid) s1_q <= s1_nxt;
         out_vld <= s1_vld;
         if (s1_vld) out_q <= res;
      end
   end

   assign bus.out_valid     = out_vld;
   assign bus.out_data      = out_q.data;
   assign bus.out_corrected = out_q.corrected;
   assign bus.out_uncorr    = out_q.uncorr;
   assign bus.out_err_pos   = out_q.err_pos;

`ifdef HD_STATS_EN
   logic xfer;
   assign xfer = out_vld && bus.out_ready;

   // Clear wins over a same-cycle increment; both counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (xfer) begin
         if (out_q.corrected && (corr_cnt != '1))  corr_cnt   <= corr_cnt + CNT_W'(1);
         if (out_q.uncorr && (uncorr_cnt != '1))   uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_hd_secded_decoder.sv
// Bench for hd_secded_decoder: codeword-level reference model, scoreboard and directed vectors.
module tb_hd_secded_decoder;
   typedef struct packed {
      logic [11:0] data;
      logic        c;
      logic        u;
      logic [4:0]  pos;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   out_count = 0;
   exp_t q[$];

   hd_secded_decoder_if bus();

`ifdef HD_STATS_EN
   logic       cnt_clr;
   logic [1:0] corr_cnt;
   logic [1:0] uncorr_cnt;
   int         m_corr = 0;
   int         m_uncorr = 0;
   hd_secded_decoder #(.CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt));
`else
   hd_secded_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] syn_of(input logic [17:0] cw);
      logic [4:0] s = '0;
      for (int k = 1; k < 18; k++) if (cw[k]) s = s ^ 5'(k);
      return s;
   endfunction

   function automatic logic [11:0] extract(input logic [17:0] cw);
      logic [11:0] d = '0;
      int j = 0;
      for (int k = 1; k < 18; k++) begin
         if ((k & (k - 1)) != 0) begin
            d[j] = cw[k];
            j++;
         end
      end
      return d;
   endfunction

   function automatic logic [17:0] enc(input logic [11:0] d);
      logic [17:0] cw = '0;
      logic [4:0]  s;
      int j = 0;
      for (int k = 1; k < 18; k++) begin
         if ((k & (k - 1)) != 0) begin
            cw[k] = d[j];
            j++;
         end
      end
      s = syn_of(cw);
      for (int i = 0; i < 5; i++) cw[1 << i] = s[i];
      cw[0] = ^cw[17:1];
      return cw;
   endfunction

   // Valid codeword -> clean; one flip away from a valid codeword -> corrected; otherwise uncorrectable.
   function automatic exp_t model(input logic [17:0] cw);
      exp_t e = '0;
      logic [17:0] t;
      if (enc(extract(cw)) == cw) begin
         e.data = extract(cw);
         return e;
      end
      for (int b = 0; b < 18; b++) begin
         t = cw ^ (18'd1 << b);
         if (enc(extract(t)) == t) begin
            e.data = extract(t);
            e.c    = 1'b1;
            e.pos  = 5'(b);
            return e;
         end
      end
      e.data = extract(cw);
      e.u    = 1'b1;
      e.pos  = syn_of(cw);
      return e;
   endfunction

   // Scoreboard: outputs vs model, stall stability, counters.
   logic       stalled = 1'b0;
   logic [19:0] held;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         stalled = 1'b0;
`ifdef HD_STATS_EN
         m_corr   = 0;
         m_uncorr = 0;
`endif
      end else begin
`ifdef HD_STATS_EN
         check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
         check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
`endif
         if (stalled)
            check("stall_stable", {bus.out_valid, bus.out_data, bus.out_corrected,
                                   bus.out_uncorr, bus.out_err_pos}, held);
         e = '0;
         if (bus.out_valid && bus.out_ready) begin
            out_count++;
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h required=none", bus.out_data);
            end else begin
               e = q.pop_front();
               check("out_word", {bus.out_data, bus.out_corrected, bus.out_uncorr, bus.out_err_pos}, e);
            end
         end
`ifdef HD_STATS_EN
         if (cnt_clr) begin
            m_corr   = 0;
            m_uncorr = 0;
         end else begin
            if (e.c && m_corr < 3)   m_corr++;
            if (e.u && m_uncorr < 3) m_uncorr++;
         end
`endif
         stalled = bus.out_valid && !bus.out_ready;
         held    = {bus.out_valid, bus.out_data, bus.out_corrected, bus.out_uncorr, bus.out_err_pos};
         if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_cw));
      end
   end

   // Single word through an empty pipeline with out_ready=1, checked against literals.
   task automatic lit(input string name, input logic [17:0] cw, input logic [11:0] d,
                      input logic c, input logic u, input logic [4:0] pos);
      @(posedge clk); #1;
      bus.in_cw = cw; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({name, "_early"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_data"}, 32'(bus.out_data), 32'(d));
      check({name, "_flags"}, {bus.out_corrected, bus.out_uncorr}, {c, u});
      check({name, "_pos"}, 32'(bus.out_err_pos), 32'(pos));
   endtask

   // Caller is just after a posedge; returns just after the accepting posedge.
   task automatic push(input logic [17:0] cw);
      int n = 0;
      bus.in_cw = cw;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL push_timeout actual=in_ready_low required=accept_within_100");
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [17:0] stream_cw(input int i);
      logic [17:0] cw = enc(12'(i * 149 + 7));
      case (i % 5)
         1: cw = cw ^ (18'd1 << ((i * 7) % 18));
         2: cw = cw ^ (18'd1 << (i % 9)) ^ (18'd1 << (9 + i % 9));
         3: cw = cw ^ (18'd1 << (i % 6)) ^ (18'd1 << (6 + i % 6)) ^ (18'd1 << (12 + i % 6));
         4: cw = cw ^ 18'd1;
         default: ;
      endcase
      return cw;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   bit         toggle_on;
   logic [6:0] rdy_pat = 7'b1011001;
   int         base;
   exp_t       me;

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_cw = '0;
      bus.out_ready = 1'b1;
`ifdef HD_STATS_EN
      cnt_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_flags", {bus.out_corrected, bus.out_uncorr, bus.out_err_pos}, 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Pin the model against hand-computed values.
      check("model_enc_001", 32'(enc(12'h001)), 32'h0000F);
      me = model(18'h00018);
      check("model_dbl", 32'(me), {12'h001, 1'b0, 1'b1, 5'd7});

      lit("clean", 18'h00000, 12'h000, 1'b0, 1'b0, 5'd0);
      lit("pos3", 18'h00008, 12'h000, 1'b1, 1'b0, 5'd3);
      lit("pos0", 18'h00001, 12'h000, 1'b1, 1'b0, 5'd0);
      lit("double", 18'h00018, 12'h001, 1'b0, 1'b1, 5'd7);
      lit("syn19", 18'h10006, 12'h000, 1'b0, 1'b1, 5'd19);
      lit("d17", 18'h20000 ^ enc(12'h800), 12'h800, 1'b1, 1'b0, 5'd17);

      // Mixed stream with a changing out_ready pattern.
      @(posedge clk); #1;
      toggle_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 48; i++) push(stream_cw(i));
            toggle_on = 1'b0;
         end
         begin
            int c = 0;
            while (toggle_on) begin
               @(posedge clk); #1;
               bus.out_ready = rdy_pat[c % 7];
               c++;
            end
         end
      join
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("stream_drained", 32'(q.size()), 32'd0);

      // A, B held by a stalled output; C waits.
      base = out_count;
      bus.out_ready = 1'b0;
      bus.in_cw = enc(12'hA5A); bus.in_valid = 1'b1;
      @(negedge clk); check("stall_rdy_a", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1 bus.in_cw = enc(12'h3C3) ^ 18'h00020;
      @(negedge clk); check("stall_rdy_b", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1 bus.in_cw = enc(12'h0F0) ^ 18'h00208;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); check("stall_rdy_c", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk); #1 bus.out_ready = 1'b1;
      @(negedge clk); check("stall_release", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("stall_count", 32'(out_count - base), 32'd3);

`ifdef HD_STATS_EN
      @(posedge clk); #1 cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      check("clr_corr", 32'(corr_cnt), 32'd0);
      check("clr_uncorr", 32'(uncorr_cnt), 32'd0);
      for (int i = 0; i < 5; i++) push(enc(12'(i * 311)) ^ (18'd1 << (i + 3)));
      repeat (4) @(posedge clk);
      #1 check("corr_sat", 32'(corr_cnt), 32'd3);
      push(18'h00018);
      repeat (4) @(posedge clk);
      #1 check("uncorr_one", 32'(uncorr_cnt), 32'd1);
      // Clear coincides with a corrected word leaving the pipe.
      bus.in_cw = 18'h00008; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(posedge clk); #1 cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      check("clr_prio_corr", 32'(corr_cnt), 32'd0);
      check("clr_prio_uncorr", 32'(uncorr_cnt), 32'd0);
`endif

      // Asynchronous reset with two words in flight.
      bus.out_ready = 1'b0;
      bus.in_cw = enc(12'h123) ^ 18'h00040; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_cw = enc(12'h456);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_word", {bus.out_data, bus.out_corrected, bus.out_uncorr, bus.out_err_pos}, 32'd0);
`ifdef HD_STATS_EN
      check("mid_rst_cnt", {corr_cnt, uncorr_cnt}, 32'd0);
`endif
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_empty", 32'(bus.out_valid), 32'd0);
      end
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);
      lit("after_rst", 18'h00008, 12'h000, 1'b1, 1'b0, 5'd3);
      repeat (3) @(posedge clk);
      #1 check("final_drained", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
